retire_trace_emitter: RTL and testbench
=======================================

// Module: retire_trace_emitter
// PURPOSE
//  Producer side of the retirement-trace stream. Samples the CPU's per-cycle retirement signals and packs them into
//  typed trace records (REG, LOAD, STORE, NOP, HALT), each carrying a running instruction number.
//  Records are buffered in a FIFO and drained over a valid/ready port to a host or trace sink.
//  Sits beside the CPU top level. Back-pressures the core with stall, and marks completion after HALT drains.
// PARAMETERS
//  DEPTH   8   FIFO entries; power of 2, >=2
//  INUM_W  32  width of instruction-number field
//  CYC_W   32  width of cycle stamp (used only with TRACE_CYCLE_EN)
// PORTS
//  clk          in   1    clock; all state updates on rising edge
//  rst          in   1    synchronous reset, active-high
//  retire_valid in   1    one instruction retires this cycle
//  pc           in   16   PC of retiring instruction
//  write_reg    in   1    register-file write
//  dest_reg     in   4    destination register
//  dst_data     in   16   register write data
//  mem_read     in   1    data-memory read
//  mem_write    in   1    data-memory write
//  mem_addr     in   16   data-memory address
//  mem_data     in   16   store data
//  hlt          in   1    HLT retiring
//  stall        out  1    FIFO full; core must hold retirement
//  trace_valid  out  1    record available
//  trace_ready  in   1    sink accepts record
//  trace_data   out  REC_W  packed record (REC_W from trace_pkg)
//  overflow     out  1    sticky; a retirement was dropped
//  done         out  1    HALT record emitted and FIFO empty
// BEHAVIOUR
//  Record layout, MSB->LSB: {kind[2:0], inum[INUM_W-1:0], pc[15:0], reg[3:0], a[15:0], b[15:0]}.
//  Kind priority, first match wins:
//   - write_reg & mem_read -> LOAD: reg=dest_reg, a=dst_data, b=mem_addr
//   - write_reg -> REG: reg=dest_reg, a=dst_data, b=0
//   - hlt -> HALT: reg=0, a=0, b=0
//   - mem_write -> STORE: reg=0, a=mem_addr, b=mem_data
//   - otherwise -> NOP: reg=0, a=0, b=0
//  inum: the first record after reset is 0. Increments by 1 per enqueued record and wraps modulo 2^INUM_W.
//  Dropped retirements do not increment inum.
//  States:
//   - RUN: accepts retirements.
//   - HALTED: entered on the edge that enqueues a HALT record. Further retire_valid is ignored, with no overflow.
//   - DONE: entered from HALTED when the FIFO is empty. Terminal until rst.
//  Latency: a retirement sampled at edge N gives trace_valid=1 after edge N, i.e. 1 cycle.
//  FIFO is first-word-fall-through. trace_data is stable while trace_valid & ~trace_ready.
//  Dequeue occurs on any edge with trace_valid & trace_ready.
//  stall = (count==DEPTH), combinational from registered count.
//  Full + retire_valid + dequeue in the same cycle: enqueue accepted, count unchanged.
//  Full + retire_valid, no dequeue: record dropped, overflow<=1, sticky until rst.
//  Empty + retire_valid + trace_ready: no bypass; record appears the next cycle.
//  done=1 only in DONE.
//  Reset values: count=0, inum=0, state=RUN, trace_valid=0, stall=0, overflow=0, done=0, trace_data=0.
//  rst during operation discards all FIFO contents. The next record is inum 0.
// CONFIGURATION
//  TRACE_CYCLE_EN defined:
//   - A free-running CYC_W cycle counter (0 on the first cycle after rst, wraps) is appended as the LSB field of every record.
//   - REC_W = 55+INUM_W+CYC_W.
//  TRACE_CYCLE_EN undefined: no counter, REC_W = 55+INUM_W.
// STRUCTURE
//  trace_pkg holds:
//   - kind encodings: NOP=0, REG=1, LOAD=2, STORE=3, HALT=4
//   - field offsets and the REC_W function
//   - state encodings: RUN, HALTED, DONE
//  Sub-module trace_fifo (DEPTH, REC_W): synchronous FWFT FIFO with count output.
//  Record classification, inum counter and the state machine stay in this module.
// TESTING
//  1) rst 2 cycles; retire REG r3=0x1234 at pc 0x0000 -> next cycle trace_valid=1, kind=REG, inum=0, reg=3, a=0x1234.
//  2) LOAD r5=0xBEEF addr 0x0040, then STORE addr 0x0042 data 0x00AA -> inums 0,1; LOAD b=0x0040; STORE a=0x0042, b=0x00AA.
//  3) trace_ready=0, 8 retirements (DEPTH 8) -> stall=1. A 9th retirement is dropped: overflow=1. Draining yields inums 0..7.
//  4) Full, retire with trace_ready=1 in the same cycle -> accepted, stall stays 1, overflow stays 0.
//  5) hlt retires, then 2 more retire_valid pulses -> one HALT record only. done=1 the cycle after it is dequeued.
//  6) rst asserted with 3 records queued -> trace_valid=0 next cycle. The next retirement emits inum 0.
//     With TRACE_CYCLE_EN, the stamp restarts at 0.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared encodings, field offsets and record-width helper for the retirement trace stream.
// Build option TRACE_CYCLE_EN appends a cycle stamp as the least-significant record field.
package trace_pkg;

    localparam int KIND_W  = 3;
    localparam int PC_W    = 16;
    localparam int REG_W   = 4;
    localparam int DATA_W  = 16;
    localparam int FIXED_W = KIND_W + PC_W + REG_W + DATA_W + DATA_W;

    typedef enum logic [2:0] {
        KIND_NOP   = 3'd0,
        KIND_REG   = 3'd1,
        KIND_LOAD  = 3'd2,
        KIND_STORE = 3'd3,
        KIND_HALT  = 3'd4
    } kind_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Width of the optional trailing cycle stamp; zero when the stamp is compiled out.
    function automatic int stamp_w(input int cyc_w);
`ifdef TRACE_CYCLE_EN
        return cyc_w;
`else
        return 32'd0;
`endif
    endfunction

    function automatic int rec_w(input int inum_w, input int cyc_w);
        return FIXED_W + inum_w + stamp_w(cyc_w);
    endfunction

    function automatic int off_b(input int cyc_w);
        return stamp_w(cyc_w);
    endfunction

    function automatic int off_a(input int cyc_w);
        return off_b(cyc_w) + DATA_W;
    endfunction

    function automatic int off_reg(input int cyc_w);
        return off_a(cyc_w) + DATA_W;
    endfunction

    function automatic int off_pc(input int cyc_w);
        return off_reg(cyc_w) + REG_W;
    endfunction

    function automatic int off_inum(input int cyc_w);
        return off_pc(cyc_w) + PC_W;
    endfunction

    function automatic int off_kind(input int inum_w, input int cyc_w);
        return off_inum(cyc_w) + inum_w;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO holding packed trace records, with an occupancy count.
module trace_fifo #(
    parameter  int DEPTH = 8,
    parameter  int REC_W = 87,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [REC_W-1:0] wr_data,
    input  logic             pop,
    output logic             rd_valid,
    output logic [REC_W-1:0] rd_data,
    output logic [CNT_W-1:0] count
);

    logic [REC_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointer and occupancy update; pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Head is forced to zero while empty so stale storage never leaks onto the port.
    assign rd_valid = (count_q != '0);
    assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
    assign count    = count_q;

endmodule

// File: rtl/retire_trace_emitter.sv
// Classifies per-cycle CPU retirements into numbered trace records and streams them out via a FIFO.
// Build option TRACE_CYCLE_EN stamps every record with a free-running cycle count.
module retire_trace_emitter
    import trace_pkg::*;
#(
    parameter  int DEPTH  = 8,
    parameter  int INUM_W = 32,
    parameter  int CYC_W  = 32,
    localparam int REC_W  = rec_w(INUM_W, CYC_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             retire_valid,
    input  logic [15:0]      pc,
    input  logic             write_reg,
    input  logic [3:0]       dest_reg,
    input  logic [15:0]      dst_data,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [15:0]      mem_addr,
    input  logic [15:0]      mem_data,
    input  logic             hlt,
    output logic             stall,
    output logic             trace_valid,
    input  logic             trace_ready,
    output logic [REC_W-1:0] trace_data,
    output logic             overflow,
    output logic             done
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0]  count_s;
    logic              full_s, accept_s, push_s, pop_s, drained_s;
    kind_e             kind_s;
    logic [3:0]        reg_s;
    logic [15:0]       a_s, b_s;
    logic [REC_W-1:0]  rec_s;

    state_e            state_q, state_d;
    logic [INUM_W-1:0] inum_q, inum_d;
    logic              overflow_q, overflow_d;

    assign full_s   = (count_s == CNT_W'(DEPTH));
    assign pop_s    = trace_valid & trace_ready;
    assign accept_s = retire_valid & (state_q == ST_RUN);
    // A full FIFO still takes a record when the head leaves on the same edge.
    assign push_s   = accept_s & (~full_s | pop_s);
    // No pushes happen once halted, so the FIFO is empty next cycle iff it drains now.
    assign drained_s = (count_s == '0) | ((count_s == CNT_W'(1)) & pop_s);

    // Record classification, first match wins.
    always_comb begin
        kind_s = KIND_NOP;
        reg_s  = 4'd0;
        a_s    = 16'd0;
        b_s    = 16'd0;
        if (write_reg & mem_read) begin
            kind_s = KIND_LOAD;
            reg_s  = dest_reg;
            a_s    = dst_data;
            b_s    = mem_addr;
        end else if (write_reg) begin
            kind_s = KIND_REG;
            reg_s  = dest_reg;
            a_s    = dst_data;
        end else if (hlt) begin
            kind_s = KIND_HALT;
        end else if (mem_write) begin
            kind_s = KIND_STORE;
            a_s    = mem_addr;
            b_s    = mem_data;
        end else begin
            kind_s = KIND_NOP;
        end
    end

`ifdef TRACE_CYCLE_EN
    logic [CYC_W-1:0] cyc_q, cyc_d;

    // Free-running cycle stamp.
    always_comb begin
        cyc_d = cyc_q + CYC_W'(1);
    end

    // Cycle stamp register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign rec_s = {kind_s, inum_q, pc, reg_s, a_s, b_s, cyc_q};
`else
    assign rec_s = {kind_s, inum_q, pc, reg_s, a_s, b_s};
`endif

    // Next-state logic for run/halt tracking, instruction numbering and overflow flag.
    always_comb begin
        state_d    = state_q;
        inum_d     = inum_q;
        overflow_d = overflow_q;
        if (push_s) begin
            inum_d = inum_q + INUM_W'(1);
        end else begin
            inum_d = inum_q;
        end
        if (accept_s & full_s & ~pop_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
        case (state_q)
            ST_RUN: begin
                if (push_s && (kind_s == KIND_HALT)) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: begin
                if (drained_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_HALTED;
                end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_RUN;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            inum_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inum_q     <= inum_d;
            overflow_q <= overflow_d;
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .REC_W (REC_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_s),
        .wr_data  (rec_s),
        .pop      (pop_s),
        .rd_valid (trace_valid),
        .rd_data  (trace_data),
        .count    (count_s)
    );

    assign stall    = full_s;
    assign overflow = overflow_q;
    assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_retire_trace_emitter.sv
// Directed self-checking bench for retire_trace_emitter; expected values are hand-derived per test.
module tb_retire_trace_emitter;
    import trace_pkg::*;

    localparam int INUM_W = 32;
    localparam int CYC_W  = 32;
    localparam int REC_W  = rec_w(INUM_W, CYC_W);

    logic             clk = 1'b0;
    logic             rst;
    logic             retire_valid, write_reg, mem_read, mem_write, hlt;
    logic [15:0]      pc, dst_data, mem_addr, mem_data;
    logic [3:0]       dest_reg;
    logic             stall, trace_valid, trace_ready, overflow, done;
    logic [REC_W-1:0] trace_data;

    int errors = 0;
    int checks = 0;

    retire_trace_emitter #(.DEPTH(8), .INUM_W(INUM_W), .CYC_W(CYC_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .retire_valid (retire_valid),
        .pc           (pc),
        .write_reg    (write_reg),
        .dest_reg     (dest_reg),
        .dst_data     (dst_data),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .hlt          (hlt),
        .stall        (stall),
        .trace_valid  (trace_valid),
        .trace_ready  (trace_ready),
        .trace_data   (trace_data),
        .overflow     (overflow),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] fld(input int off, input int w);
        logic [REC_W-1:0] t;
        t = trace_data >> off;
        return 64'(t) & ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] f_kind();  return fld(off_kind(INUM_W, CYC_W), KIND_W); endfunction
    function automatic logic [63:0] f_inum();  return fld(off_inum(CYC_W), INUM_W);         endfunction
    function automatic logic [63:0] f_pc();    return fld(off_pc(CYC_W), PC_W);             endfunction
    function automatic logic [63:0] f_reg();   return fld(off_reg(CYC_W), REG_W);           endfunction
    function automatic logic [63:0] f_a();     return fld(off_a(CYC_W), DATA_W);            endfunction
    function automatic logic [63:0] f_b();     return fld(off_b(CYC_W), DATA_W);            endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        retire_valid = 1'b0; write_reg = 1'b0; mem_read = 1'b0; mem_write = 1'b0; hlt = 1'b0;
        pc = 16'd0; dest_reg = 4'd0; dst_data = 16'd0; mem_addr = 16'd0; mem_data = 16'd0;
    endtask

    task automatic retire(input logic wr, input logic mr, input logic mw, input logic h,
                          input logic [3:0] rd, input logic [15:0] p, input logic [15:0] dd,
                          input logic [15:0] ma, input logic [15:0] md);
        retire_valid = 1'b1; write_reg = wr; mem_read = mr; mem_write = mw; hlt = h;
        dest_reg = rd; pc = p; dst_data = dd; mem_addr = ma; mem_data = md;
    endtask

    task automatic do_reset();
        rst = 1'b1; idle(); trace_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state.
        do_reset();
        rst = 1'b1;
        tick();
        check("rst_valid", 64'(trace_valid), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_data", 64'(trace_data), 64'd0);
        rst = 1'b0;

        // 1) single REG record, one-cycle latency.
        retire(1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 16'h0000, 16'h1234, 16'h0000, 16'h0000);
        tick(); idle();
        check("t1_valid", 64'(trace_valid), 64'd1);
        check("t1_kind", f_kind(), 64'd1);
        check("t1_inum", f_inum(), 64'd0);
        check("t1_reg", f_reg(), 64'd3);
        check("t1_a", f_a(), 64'h1234);
        check("t1_b", f_b(), 64'd0);
        trace_ready = 1'b1; tick(); trace_ready = 1'b0;
        check("t1_empty", 64'(trace_valid), 64'd0);

        // 2) LOAD, STORE, NOP plus a write_reg+hlt priority case.
        do_reset();
        retire(1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 16'h0002, 16'hBEEF, 16'h0040, 16'h0000); tick();
        retire(1'b0, 1'b0, 1'b1, 1'b0, 4'd9, 16'h0004, 16'h7777, 16'h0042, 16'h00AA); tick();
        retire(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0006, 16'h0000, 16'h0000, 16'h0000); tick();
        retire(1'b1, 1'b0, 1'b1, 1'b1, 4'd7, 16'h0008, 16'h5A5A, 16'h0011, 16'h0022); tick();
        idle();
        check("t2_ld_kind", f_kind(), 64'd2);
        check("t2_ld_inum", f_inum(), 64'd0);
        check("t2_ld_pc", f_pc(), 64'h0002);
        check("t2_ld_reg", f_reg(), 64'd5);
        check("t2_ld_a", f_a(), 64'hBEEF);
        check("t2_ld_b", f_b(), 64'h0040);
        trace_ready = 1'b1; tick(); trace_ready = 1'b0;
        check("t2_st_kind", f_kind(), 64'd3);
        check("t2_st_inum", f_inum(), 64'd1);
        check("t2_st_reg", f_reg(), 64'd0);
        check("t2_st_a", f_a(), 64'h0042);
        check("t2_st_b", f_b(), 64'h00AA);
        trace_ready = 1'b1; tick(); trace_ready = 1'b0;
        check("t2_nop_kind", f_kind(), 64'd0);
        check("t2_nop_inum", f_inum(), 64'd2);
        check("t2_nop_pc", f_pc(), 64'h0006);
        trace_ready = 1'b1; tick(); trace_ready = 1'b0;
        check("t2_prio_kind", f_kind(), 64'd1);
        check("t2_prio_reg", f_reg(), 64'd7);
        check("t2_prio_a", f_a(), 64'h5A5A);
        check("t2_prio_done", 64'(done), 64'd0);

        // 3) fill to DEPTH, drop one, drain in order.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            retire(1'b1, 1'b0, 1'b0, 1'b0, 4'(i), 16'(i), 16'h0100 + 16'(i), 16'h0000, 16'h0000);
            tick();
            if (i == 6) check("t3_stall7", 64'(stall), 64'd0);
        end
        check("t3_stall", 64'(stall), 64'd1);
        check("t3_ovf0", 64'(overflow), 64'd0);
        retire(1'b1, 1'b0, 1'b0, 1'b0, 4'd15, 16'h00FF, 16'hDEAD, 16'h0000, 16'h0000);
        tick(); idle();
        check("t3_ovf1", 64'(overflow), 64'd1);
        trace_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t3_drain_inum", f_inum(), 64'(i));
            check("t3_drain_a", f_a(), 64'h0100 + 64'(i));
            tick();
        end
        trace_ready = 1'b0;
        check("t3_empty", 64'(trace_valid), 64'd0);
        check("t3_ovf_sticky", 64'(overflow), 64'd1);

        // 4) full with simultaneous dequeue accepts the new record.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            retire(1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 16'(i), 16'h0200 + 16'(i), 16'h0000, 16'h0000);
            tick();
        end
        retire(1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 16'h0050, 16'h0AAA, 16'h0000, 16'h0000);
        trace_ready = 1'b1; tick(); idle(); trace_ready = 1'b0;
        check("t4_stall", 64'(stall), 64'd1);
        check("t4_ovf", 64'(overflow), 64'd0);
        trace_ready = 1'b1;
        for (int i = 1; i < 9; i++) begin
            check("t4_drain_inum", f_inum(), 64'(i));
            tick();
        end
        trace_ready = 1'b0;
        check("t4_empty", 64'(trace_valid), 64'd0);

        // 5) HALT (mem_write+hlt still classifies as HALT) then ignored retirements.
        do_reset();
        retire(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 16'h0010, 16'h0000, 16'h0033, 16'h0044); tick();
        retire(1'b1, 1'b0, 1'b0, 1'b0, 4'd4, 16'h0012, 16'h1111, 16'h0000, 16'h0000); tick();
        retire(1'b1, 1'b0, 1'b0, 1'b0, 4'd4, 16'h0014, 16'h2222, 16'h0000, 16'h0000); tick();
        idle();
        check("t5_kind", f_kind(), 64'd4);
        check("t5_inum", f_inum(), 64'd0);
        check("t5_a", f_a(), 64'd0);
        check("t5_b", f_b(), 64'd0);
        check("t5_done0", 64'(done), 64'd0);
        check("t5_ovf", 64'(overflow), 64'd0);
        trace_ready = 1'b1; tick(); trace_ready = 1'b0;
        check("t5_done1", 64'(done), 64'd1);
        check("t5_one_rec", 64'(trace_valid), 64'd0);
        tick();
        check("t5_done_hold", 64'(done), 64'd1);

        // 6) reset with records queued discards them and restarts numbering.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            retire(1'b1, 1'b0, 1'b0, 1'b0, 4'd6, 16'(i), 16'h0300, 16'h0000, 16'h0000);
            tick();
        end
        idle();
        rst = 1'b1; tick();
        check("t6_flush", 64'(trace_valid), 64'd0);
        rst = 1'b0;
        retire(1'b1, 1'b0, 1'b0, 1'b0, 4'd8, 16'h0020, 16'h0404, 16'h0000, 16'h0000);
        tick(); idle();
        check("t6_valid", 64'(trace_valid), 64'd1);
        check("t6_inum", f_inum(), 64'd0);
`ifdef TRACE_CYCLE_EN
        check("t6_stamp", fld(0, CYC_W), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
